// File: rtl/pacoblaze_io_pkg.sv
// Shared types and default addresses for the pacoblaze I/O and interrupt peripheral.
package pacoblaze_io_pkg;

  // Default port_id addresses of the interrupt controller registers.
  localparam logic [7:0] IO_IRQ_STAT_ADDR_DEF = 8'hF0;
  localparam logic [7:0] IO_IRQ_MASK_ADDR_DEF = 8'hF1;

  // Interrupt acknowledge handshake: SERVICE holds the request low until the ISR clears pending.
  typedef enum logic {
    IO_IDLE    = 1'b0,
    IO_SERVICE = 1'b1
  } io_state_e;

endpackage : pacoblaze_io_pkg

// File: rtl/io_sync2.sv
// Parametrised-width two-flop synchroniser for asynchronous inputs.
module io_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two register stages; the first may go metastable, the second gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so sync_q takes the old meta_q, forming a real two-stage chain.
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : io_sync2

// File: rtl/pacoblaze_io.sv
// Port-mapped output registers, synchronised input ports and an edge-triggered
// interrupt controller (mask, write-1-to-clear pending, ack handshake) for pacoblaze.
module pacoblaze_io
  import pacoblaze_io_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               N_OUT         = 4,
  parameter int               N_IN          = 4,
  parameter int               N_IRQ         = 8,
  parameter logic [WIDTH-1:0] BASE_OUT      = '0,
  parameter logic [WIDTH-1:0] BASE_IN       = '0,
  parameter logic [WIDTH-1:0] IRQ_STAT_ADDR = WIDTH'(IO_IRQ_STAT_ADDR_DEF),
  parameter logic [WIDTH-1:0] IRQ_MASK_ADDR = WIDTH'(IO_IRQ_MASK_ADDR_DEF),
  parameter bit               IRQ_RISING    = 1'b1
) (
  input  logic                   MCKO,
  input  logic                   nRST,
  input  logic [WIDTH-1:0]       port_id,
  input  logic                   write_strobe,
  input  logic                   read_strobe,
  input  logic [WIDTH-1:0]       out_port,
  output logic [WIDTH-1:0]       in_port,
  output logic                   interrupt,
  input  logic                   interrupt_ack,
  output logic [N_OUT*WIDTH-1:0] pins_out,
  input  logic [N_IN*WIDTH-1:0]  pins_in,
  input  logic [N_IRQ-1:0]       irq_src
);

  logic [N_OUT*WIDTH-1:0] out_q, out_d;
  logic [N_IN*WIDTH-1:0]  pins_sync;
  logic [N_IRQ-1:0]       irq_sync, irq_hist_q, irq_edge;
  logic [N_IRQ-1:0]       pending_q, pending_d;
  logic [N_IRQ-1:0]       mask_q, mask_d;
  logic [N_IRQ-1:0]       stat_clr;
  logic                   irq_q, irq_d;
  io_state_e              state_q, state_d;
  logic                   wr_stat, wr_mask;

  // The core samples in_port regardless of read_strobe, so the strobe has no effect here.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  io_sync2 #(.W(N_IN*WIDTH)) u_pin_sync (
    .clk   (MCKO),
    .rst_n (nRST),
    .d_i   (pins_in),
    .q_o   (pins_sync)
  );

  io_sync2 #(.W(N_IRQ)) u_irq_sync (
    .clk   (MCKO),
    .rst_n (nRST),
    .d_i   (irq_src),
    .q_o   (irq_sync)
  );

  assign wr_stat  = write_strobe && (port_id == IRQ_STAT_ADDR);
  assign wr_mask  = write_strobe && (port_id == IRQ_MASK_ADDR);
  assign stat_clr = wr_stat ? out_port[N_IRQ-1:0] : {N_IRQ{1'b0}};
  assign irq_edge = IRQ_RISING ? (irq_sync & ~irq_hist_q) : (~irq_sync & irq_hist_q);

  // Output register decode and interrupt register next-state; an edge wins over a same-cycle clear.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    out_d     = out_q;
    for (int k = 0; k < N_OUT; k++) begin
      if (write_strobe && (port_id == BASE_OUT + WIDTH'(k))) begin
        out_d[k*WIDTH +: WIDTH] = out_port;
      end
    end
    mask_d    = wr_mask ? out_port[N_IRQ-1:0] : mask_q;
    pending_d = (pending_q & ~stat_clr) | irq_edge;
  end

  // Ack handshake: request is held low from ack until the ISR writes the pending register.
  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    unique case (state_q)
      IO_IDLE: begin
        if (interrupt_ack) state_d = IO_SERVICE;
        else               irq_d   = |(pending_q & mask_q);
      end
      IO_SERVICE: begin
        if (wr_stat) state_d = IO_IDLE;
      end
      default: state_d = IO_IDLE;
    endcase
  end

  // All peripheral state; reset clears everything, discarding any in-flight write.
  always_ff @(posedge MCKO or negedge nRST) begin
    if (!nRST) begin
      out_q      <= '0;
      irq_hist_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_q      <= 1'b0;
      state_q    <= IO_IDLE;
    end else begin
      out_q      <= out_d;
      irq_hist_q <= irq_sync;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      irq_q      <= irq_d;
      state_q    <= state_d;
    end
  end

  // Combinational read mux: status beats mask, mask beats the input ports, unmapped reads 0.
  always_comb begin
    in_port = '0;
    if (port_id == IRQ_STAT_ADDR) begin
      in_port[N_IRQ-1:0] = pending_q;
    end else if (port_id == IRQ_MASK_ADDR) begin
      in_port[N_IRQ-1:0] = mask_q;
    end else begin
      for (int k = 0; k < N_IN; k++) begin
        if (port_id == BASE_IN + WIDTH'(k)) in_port = pins_sync[k*WIDTH +: WIDTH];
      end
    end
  end

  assign pins_out  = out_q;
  assign interrupt = irq_q;

endmodule : pacoblaze_io

// File: tb/tb_pacoblaze_io.sv
// Self-checking bench for pacoblaze_io: directed test-plan scenarios followed by
// randomised bus/pin/irq traffic, all compared against a cycle-level behavioural model.
module tb_pacoblaze_io;

  logic        MCKO = 1'b0;
  logic        nRST;
  logic [7:0]  port_id;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  out_port;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic [31:0] pins_out;
  logic [31:0] pins_in;
  logic [7:0]  irq_src;

  int n_checks = 0;
  int n_errors = 0;

  pacoblaze_io #(
    .WIDTH(8), .N_OUT(4), .N_IN(4), .N_IRQ(8),
    .BASE_OUT(8'h00), .BASE_IN(8'h00),
    .IRQ_STAT_ADDR(8'hF0), .IRQ_MASK_ADDR(8'hF1), .IRQ_RISING(1'b1)
  ) dut (
    .MCKO          (MCKO),
    .nRST          (nRST),
    .port_id       (port_id),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .out_port      (out_port),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .pins_out      (pins_out),
    .pins_in       (pins_in),
    .irq_src       (irq_src)
  );

  always #5 MCKO = ~MCKO;

  // Behavioural model: register values plus per-edge sample histories of the pins and sources.
  logic [7:0]  m_out [4];
  logic [7:0]  m_mask, m_pend;
  logic        m_irq, m_svc;
  logic [31:0] m_pin_h [2];   // [0] = pins_in at last edge, [1] = one edge earlier (readable)
  logic [7:0]  m_src_h [3];   // irq_src samples at last three edges, newest first

  wire        m_wr_stat = write_strobe && (port_id == 8'hF0);
  wire        m_wr_mask = write_strobe && (port_id == 8'hF1);
  wire [7:0]  m_clr     = m_wr_stat ? out_port : 8'h00;
  wire [7:0]  m_rise    = m_src_h[1] & ~m_src_h[2];

  always @(posedge MCKO or negedge nRST) begin
    if (!nRST) begin
      for (int k = 0; k < 4; k++) m_out[k] <= 8'h00;
      m_mask <= 8'h00;
      m_pend <= 8'h00;
      m_irq  <= 1'b0;
      m_svc  <= 1'b0;
      m_pin_h[0] <= '0;
      m_pin_h[1] <= '0;
      for (int k = 0; k < 3; k++) m_src_h[k] <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++) if (write_strobe && port_id == 8'(k)) m_out[k] <= out_port;
      if (m_wr_mask) m_mask <= out_port;
      m_pend <= (m_pend & ~m_clr) | m_rise;
      m_irq  <= !m_svc && !interrupt_ack && ((m_pend & m_mask) != 8'h00);
      if (!m_svc && interrupt_ack) m_svc <= 1'b1;
      else if (m_svc && m_wr_stat) m_svc <= 1'b0;
      m_pin_h[1] <= m_pin_h[0];
      m_pin_h[0] <= pins_in;
      m_src_h[2] <= m_src_h[1];
      m_src_h[1] <= m_src_h[0];
      m_src_h[0] <= irq_src;
    end
  end

  function automatic logic [7:0] exp_rd(input logic [7:0] id);
    if (id == 8'hF0) return m_pend;
    if (id == 8'hF1) return m_mask;
    if (id < 8'd4)   return m_pin_h[1][id[1:0]*8 +: 8];
    return 8'h00;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge, then compare every output against the model away from the edge.
  task automatic tick();
    @(posedge MCKO);
    #1;
    check("mdl_pins_out",  pins_out,  {m_out[3], m_out[2], m_out[1], m_out[0]});
    check("mdl_interrupt", interrupt, m_irq);
    check("mdl_in_port",   in_port,   exp_rd(port_id));
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    port_id      = id;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] id, input logic [7:0] exp);
    port_id = id;
    #1;
    check(tag, in_port, exp);
  endtask

  initial begin
    nRST = 1'b0; port_id = 8'h00; write_strobe = 1'b0; read_strobe = 1'b0;
    out_port = 8'h00; interrupt_ack = 1'b0; pins_in = '0; irq_src = 8'h00;
    repeat (3) tick();
    check("reset_pins_out", pins_out, 32'h0);
    check("reset_interrupt", interrupt, 1'b0);
    nRST = 1'b1;

    // Write decode
    wr(8'h02, 8'hA5);
    check("wr_port2", pins_out, 32'h00A5_0000);
    wr(8'h07, 8'hFF);
    check("wr_unmapped", pins_out, 32'h00A5_0000);

    // Input synchroniser latency and unmapped read
    pins_in = 32'h0000_3C00;
    tick(); tick();
    rd("rd_in1", 8'h01, 8'h3C);
    rd("rd_unmapped", 8'h55, 8'h00);

    // Edge -> pending (3 cycles) -> interrupt (4 cycles), then ack and clear
    wr(8'hF1, 8'h04);
    irq_src = 8'h04;
    tick(); tick();
    rd("pend_early", 8'hF0, 8'h00);
    tick();
    rd("pend_set", 8'hF0, 8'h04);
    check("irq_not_yet", interrupt, 1'b0);
    tick();
    check("irq_raised", interrupt, 1'b1);
    irq_src = 8'h00;
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("irq_ack_drop", interrupt, 1'b0);
    wr(8'hF0, 8'h04);
    rd("pend_cleared", 8'hF0, 8'h00);
    tick();
    check("irq_stays_low", interrupt, 1'b0);

    // Masked pending still latches; unmask raises interrupt
    wr(8'hF1, 8'h00);
    irq_src = 8'h01;
    repeat (3) tick();
    rd("pend_masked", 8'hF0, 8'h01);
    check("irq_masked", interrupt, 1'b0);
    wr(8'hF1, 8'h01);
    tick();
    check("irq_unmask", interrupt, 1'b1);

    // Set beats clear: W1C lands on the same edge that sets pending[0]
    irq_src = 8'h00;
    repeat (4) tick();
    irq_src = 8'h01;
    tick(); tick();
    wr(8'hF0, 8'h01);
    rd("set_beats_clear", 8'hF0, 8'h01);
    wr(8'hF0, 8'h01);
    rd("plain_clear", 8'hF0, 8'h00);
    tick();
    check("irq_after_clear", interrupt, 1'b0);

    // Remaining pending source re-raises interrupt after leaving SERVICE
    wr(8'hF1, 8'h03);
    irq_src = 8'h00;
    repeat (4) tick();
    irq_src = 8'h03;
    repeat (3) tick();
    rd("pend_two", 8'hF0, 8'h03);
    tick();
    check("irq_two", interrupt, 1'b1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    check("irq_svc", interrupt, 1'b0);
    wr(8'hF0, 8'h01);
    check("irq_leave_svc", interrupt, 1'b0);
    rd("pend_left", 8'hF0, 8'h02);
    tick();
    check("irq_reraise", interrupt, 1'b1);

    // Asynchronous reset during a mask write
    wr(8'hF1, 8'hFF);
    port_id = 8'hF1; out_port = 8'hFF; write_strobe = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    check("async_mask", in_port, 8'h00);
    check("async_irq", interrupt, 1'b0);
    check("async_pins", pins_out, 32'h0);
    write_strobe = 1'b0;
    tick(); tick();
    nRST = 1'b1;

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 9))
        0: port_id = 8'h00;
        1: port_id = 8'h01;
        2: port_id = 8'h02;
        3: port_id = 8'h03;
        4: port_id = 8'h04;
        5: port_id = 8'hF0;
        6: port_id = 8'hF1;
        7: port_id = 8'hF0;
        8: port_id = 8'h55;
        default: port_id = 8'($urandom);
      endcase
      write_strobe = 1'($urandom_range(0, 1));
      out_port     = 8'($urandom);
      if ($urandom_range(0, 3) == 0) pins_in = $urandom;
      if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ 8'($urandom);
      interrupt_ack = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pacoblaze_io

// File: doc/pacoblaze_io.md
Name: pacoblaze_io

Overview:
- Parametrised I/O and interrupt peripheral that sits between the pacoblaze core's port bus and board pins.
- Replaces direct pin wiring, where out_port drove pins, D[7:0] fed in_port and a single pin drove interrupt.
- Provides N_OUT latched output ports and N_IN synchronised input ports, both decoded on port_id.
- Provides an N_IRQ-source edge-triggered interrupt controller with mask and write-1-to-clear pending registers.

Parameters:
- WIDTH, 8: operand width; matches `operand_width.
- N_OUT, 4: number of output port registers (1..16).
- N_IN, 4: number of input ports (1..16).
- N_IRQ, 8: interrupt sources (1..WIDTH).
- BASE_OUT, 8'h00: port_id of output register 0; register k is at BASE_OUT+k.
- BASE_IN, 8'h00: port_id of input port 0; port k is at BASE_IN+k.
- IRQ_STAT_ADDR, 8'hF0: pending register (read; write-1-to-clear).
- IRQ_MASK_ADDR, 8'hF1: mask register (read/write).
- IRQ_RISING, 1: 1 = rising-edge sources, 0 = falling-edge sources.

Ports:
- MCKO  in  1  system clock; every flop is clocked on its rising edge.
- nRST  in  1  asynchronous active-low reset.
- port_id  in  WIDTH  core port address.
- write_strobe  in  1  core write strobe.
- read_strobe  in  1  core read strobe; only observed, no side effects.
- out_port  in  WIDTH  core write data.
- in_port  out  WIDTH  read data to core.
- interrupt  out  1  interrupt request to core.
- interrupt_ack  in  1  core interrupt acknowledge.
- pins_out  out  N_OUT*WIDTH  output registers; register k at bits [k*WIDTH +: WIDTH].
- pins_in  in  N_IN*WIDTH  asynchronous pin inputs, same packing as pins_out.
- irq_src  in  N_IRQ  asynchronous interrupt sources.

Behaviour:
- Reset (nRST low, asynchronous):
  - pins_out = 0, mask = 0, pending = 0, interrupt = 0.
  - All synchroniser and edge-history flops = 0.
  - Reset asserted mid-transaction discards that write.
- Output writes:
  - When write_strobe=1 and port_id = BASE_OUT+k (k<N_OUT), register k <= out_port on the next edge. Write-to-pin latency is 1 cycle.
  - Writes to unmapped IDs are ignored.
  - A write to a shared address updates the output register and the IRQ register together.
- Input path: each pins_in bit passes through a 2-flop synchroniser, so pin-to-readable latency is 2 cycles.
- Read mux (in_port) is combinational on port_id and independent of read_strobe, because the core samples in_port during its INPUT cycle:
  - BASE_IN+k → synchronised input k.
  - IRQ_STAT_ADDR → pending, zero-extended to WIDTH.
  - IRQ_MASK_ADDR → mask, zero-extended.
  - Anything else → 0.
  - Priority: IRQ_STAT, then IRQ_MASK, then input ports.
- Interrupt sources:
  - Each irq_src bit: 2-flop synchroniser, then a history flop.
  - Edge detected = sync & ~hist when IRQ_RISING=1, else ~sync & hist.
  - An edge sets pending[i] on the next cycle.
  - Source-to-pending latency is 3 cycles.
- Pending clear:
  - A write to IRQ_STAT_ADDR clears every pending bit where out_port bit = 1.
  - If an edge and a clear hit the same bit in the same cycle, the set wins.
- Mask: a write to IRQ_MASK_ADDR loads mask <= out_port[N_IRQ-1:0].
- interrupt output:
  - Registered: interrupt <= |(pending & mask), which satisfies the core's ≥2-cycle hold requirement.
  - Latency from pending set (with mask already set) to interrupt is 1 cycle.
- interrupt_ack FSM, states IDLE and SERVICE:
  - IDLE → SERVICE on interrupt_ack. In SERVICE, interrupt is forced to 0.
  - SERVICE → IDLE after any write to IRQ_STAT_ADDR. From the next cycle, interrupt re-evaluates |(pending & mask).
  - Result: exactly one request per ISR entry; remaining pending sources re-raise interrupt after the clear.
  - interrupt_ack while in SERVICE is ignored.
- Pending bits keep latching while masked; unmasking an already-pending bit raises interrupt 1 cycle later (IDLE state).
- No other counters exist, so there is no wrap-around case.

Decomposition:
- pacoblaze_inc.v: add `io_irq_stat_addr and `io_irq_mask_addr defaults; widths come from `operand_width.
- One sub-module, io_sync2: a parametrised-width 2-flop synchroniser with async active-low reset.
- io_sync2 is instantiated for pins_in (N_IN*WIDTH bits) and for irq_src (N_IRQ bits).

Test Plan:
- Reset and write decode:
  - After reset, pins_out=0 and interrupt=0.
  - Write 8'hA5 to port 8'h02 → pins_out[23:16]=8'hA5 one cycle later; all other bytes stay 0.
  - Write to 8'h07 changes nothing.
- Input read:
  - Set pins_in[15:8]=8'h3C, wait 2 cycles, set port_id=8'h01 → in_port=8'h3C.
  - port_id=8'h55 → in_port=8'h00.
- Interrupt and ack:
  - mask=8'h04; pulse irq_src[2] high → pending=8'h04 at +3 cycles, interrupt=1 at +4.
  - Assert interrupt_ack → interrupt=0 the next cycle.
  - Write 8'h04 to 8'hF0 → pending=0, interrupt stays 0.
- Masked latch and set-beats-clear:
  - With mask=0, raise irq_src[0] → pending=8'h01, interrupt=0.
  - Write mask 8'h01 → interrupt=1 one cycle later.
  - Schedule a new edge on bit 0 in the same cycle as a W1C of 8'h01 → pending[0] remains 1.
- Re-raise after clear:
  - Pending=8'h03 with mask=8'h03; ack, then clear 8'h01 → interrupt returns to 1 one cycle after leaving SERVICE.
- Mid-operation reset:
  - Drop nRST during a write_strobe to 8'hF1 → mask=0 and interrupt=0 immediately, with no clock edge required.
